// File: rtl/pol_round_pack_if.sv
// Bus bundle for pol_round_pack: PolMem read port plus the packed output stream.
interface pol_round_pack_if;
  logic [5:0]  mem_addr;
  logic        mem_ren;
  logic [63:0] mem_rdata;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_addr, mem_ren, out_data, out_valid,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_addr, mem_ren, out_data, out_valid,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/pol_round_pack.sv
// Reads the 64-word PolMem result, rounds each EQ-bit coefficient to EP bits
// and bit-packs the 256 results LSB-first into a 64-bit valid/ready stream.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | reading PolMem, rounding and emitting packed words
// DONE  | all words accepted; start launches another pass
module pol_round_pack #(
  parameter int EQ = 13,
  parameter int EP = 10,
  parameter int H1 = 1 << (EQ - EP - 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  pol_round_pack_if.master bus
);

  localparam int PUSH   = 4 * EP;
  localparam int NWORDS = 4 * EP;
  localparam int LIMIT  = 128 - PUSH;
  localparam logic [63:0] LANE_MASK = {4{16'((1 << EQ) - 1)}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       state, state_nx;
  logic [127:0] bitbuf, buf_shift, buf_nx;
  logic [7:0]   cnt_q, cnt_s, cnt_nx, proj;
  logic [6:0]   rd_cnt;
  logic [5:0]   addr_q;
  logic [5:0]   wr_cnt;
  logic         rd_pend;
  logic         ov_q;
  logic         go, pop, issue, last_pop;
  logic [EQ-1:0]   lane_sum;
  logic [PUSH-1:0] packed_lanes;
  logic         unused_hi;

  assign go       = start && (state != S_RUN);
  assign pop      = ov_q && bus.out_ready;
  assign last_pop = pop && (wr_cnt == 6'(NWORDS - 1));
  // In-flight read data counts as already resident so the buffer can never overflow.
  assign proj     = cnt_q + (rd_pend ? 8'(PUSH) : 8'd0);
  assign issue    = (state == S_RUN) && (rd_cnt < 7'd64) && (proj <= 8'(LIMIT));
  assign unused_hi = ^(bus.mem_rdata & ~LANE_MASK);

  always_comb begin
    packed_lanes = '0;
    lane_sum     = '0;
    for (int i = 0; i < 4; i++) begin
      lane_sum = bus.mem_rdata[16*i +: EQ] + EQ'(H1);
      packed_lanes[EP*i +: EP] = lane_sum[EQ-1 -: EP];
    end
  end

  always_comb begin
    buf_shift = pop ? {64'd0, bitbuf[127:64]} : bitbuf;
    cnt_s     = pop ? (cnt_q - 8'd64) : cnt_q;
    buf_nx    = buf_shift;
    cnt_nx    = cnt_s;
    if (rd_pend) begin
      buf_nx = buf_shift | ({{(128 - PUSH){1'b0}}, packed_lanes} << cnt_s);
      cnt_nx = cnt_s + 8'(PUSH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last_pop) state_nx = S_DONE;
      S_DONE:  if (start) state_nx = S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state == S_RUN);
    done          = (state == S_DONE);
    bus.mem_ren   = issue;
    bus.mem_addr  = addr_q;
    bus.out_valid = ov_q;
    bus.out_data  = bitbuf[63:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      bitbuf  <= '0;
      cnt_q   <= '0;
      rd_cnt  <= '0;
      addr_q  <= '0;
      wr_cnt  <= '0;
      rd_pend <= 1'b0;
      ov_q    <= 1'b0;
    end else if (state == S_RUN) begin
      bitbuf  <= buf_nx;
      cnt_q   <= cnt_nx;
      ov_q    <= (cnt_nx >= 8'd64);
      rd_pend <= issue;
      if (issue) begin
        rd_cnt <= rd_cnt + 7'd1;
        if (addr_q != 6'd63) addr_q <= addr_q + 6'd1;
      end
      if (pop) wr_cnt <= wr_cnt + 6'd1;
    end
  end

endmodule
